pc_sequencer: RTL and testbench

- Drives the PC/nPC register pair: next-value buses (PC_D, nPC_D) and active-high load enables (stallPC, stallnPC).
- Implements sequential fetch, branch-with-delay-slot, load-use interlock and instruction-memory wait stalls.
- Also controls the IF/ID pipeline register enable and ID/EX bubble insertion.
- Sits between decode/hazard signals and the PC/nPC registers, which reset themselves to PC=0, nPC=4.

---
 rtl/pc_sequencer_if.sv | 40 ++++
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundles the PC/nPC sequencer signals between decode/hazard
// logic (master) and the sequencer itself (slave).
//   master drives: PC_Q, nPC_Q, branch_taken, branch_target, imem_ready,
//                  id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt
//   slave drives:  PC_D, nPC_D, stallPC, stallnPC, if_id_le, id_ex_bubble,
//                  fetch_timeout, state
interface pc_sequencer_if;
  logic [31:0] PC_Q;
  logic [31:0] nPC_Q;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ready;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rt;
  logic [4:0]  if_id_rs;
  logic [4:0]  if_id_rt;
  logic        if_id_uses_rt;
  logic [31:0] PC_D;
  logic [31:0] nPC_D;
  logic        stallPC;
  logic        stallnPC;
  logic        if_id_le;
  logic        id_ex_bubble;
  logic        fetch_timeout;
  logic [1:0]  state;

  modport master (
    output PC_Q, nPC_Q, branch_taken, branch_target, imem_ready,
           id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
    input  PC_D, nPC_D, stallPC, stallnPC, if_id_le, id_ex_bubble,
           fetch_timeout, state
  );

  modport slave (
    input  PC_Q, nPC_Q, branch_taken, branch_target, imem_ready,
           id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
    output PC_D, nPC_D, stallPC, stallnPC, if_id_le, id_ex_bubble,
           fetch_timeout, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: computes next PC/nPC values and their load enables, handling
// sequential fetch, branches with a delay slot, load-use interlocks and
// instruction-memory wait stalls. Also drives the IF/ID enable and the ID/EX
// bubble.
// Ports:
//   Clk    - rising-edge clock
//   Reset  - synchronous active-high reset
//   bus    - pc_sequencer_if.slave (decode/hazard inputs, PC/nPC outputs)
// Parameters:
//   LOAD_STALL_CYCLES - cycles frozen per load-use hazard (1..15)
//   MAX_WAIT          - FETCH_WAIT cycle count that raises fetch_timeout (1..255)
module pc_sequencer #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MAX_WAIT          = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_HAZARD     = 2'd1,
    ST_FETCH_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] HCNT_INIT  = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [3:0]  hcnt_q, hcnt_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        timeout_q, timeout_d;
  logic        hazard;
  logic        go;
  logic        go_eff;

  // Load in EX writes a register the ID instruction reads; r0 never conflicts.
  assign hazard = bus.id_ex_mem_read && (bus.id_ex_rt != 5'd0) &&
                  ((bus.id_ex_rt == bus.if_id_rs) ||
                   (bus.if_id_uses_rt && (bus.id_ex_rt == bus.if_id_rt)));

  // Datapath: PC takes the old nPC (delay slot), nPC takes target or +4.
  assign bus.PC_D  = bus.nPC_Q;
  assign bus.nPC_D = bus.branch_taken ? bus.branch_target : (bus.nPC_Q + 32'd4);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_RUN;
      hcnt_q    <= 4'd0;
      wcnt_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    go        = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        // Memory wait outranks a load-use hazard.
        if (!bus.imem_ready) begin
          state_d = ST_FETCH_WAIT;
          wcnt_d  = 8'd1;
        end else if (hazard) begin
          // A single-cycle interlock is covered by this RUN cycle alone.
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = ST_HAZARD;
            hcnt_d  = HCNT_INIT;
          end
        end else begin
          go = 1'b1;
        end
      end
      ST_HAZARD: begin
        hcnt_d = hcnt_q - 4'd1;
        // hcnt_q==0 cannot occur normally; treat it as done rather than wrap.
        if (hcnt_q <= 4'd1) begin
          state_d = ST_RUN;
          hcnt_d  = 4'd0;
        end
      end
      ST_FETCH_WAIT: begin
        if (wcnt_q == WAIT_LIMIT) begin
          timeout_d = 1'b1;
        end
        // Returning to RUN re-evaluates the fetch next cycle before accepting it.
        if (bus.imem_ready) begin
          state_d = ST_RUN;
        end else if (wcnt_q != 8'hFF) begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Reset suppresses every load regardless of the FSM's opinion.
  assign go_eff = go && !Reset;

  assign bus.stallPC       = go_eff;
  assign bus.stallnPC      = go_eff;
  assign bus.if_id_le      = go_eff;
  assign bus.id_ex_bubble  = !go_eff;
  assign bus.fetch_timeout = timeout_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   cycle = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cycle <= cycle + 1;

  pc_sequencer_if ifa ();
  pc_sequencer_if ifb ();

  pc_sequencer #(.LOAD_STALL_CYCLES(1), .MAX_WAIT(16)) dut_a (
    .Clk(Clk), .Reset(Reset), .bus(ifa)
  );
  pc_sequencer #(.LOAD_STALL_CYCLES(3), .MAX_WAIT(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .bus(ifb)
  );

  typedef struct {
    int          d;
    int          cyc;
    string       tag;
    logic [31:0] pcd;
    logic [31:0] npcd;
    logic        go;
    logic        ft;
    logic [1:0]  st;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Monitor: every cycle, compare outputs against expectations queued for it.
  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].cyc == cycle) begin
      exp_t e;
      logic [31:0] pcd, npcd;
      logic s_pc, s_npc, le, bub, ft;
      logic [1:0] st;
      e = sb.pop_front();
      if (e.d == 0) begin
        pcd = ifa.PC_D; npcd = ifa.nPC_D; s_pc = ifa.stallPC; s_npc = ifa.stallnPC;
        le = ifa.if_id_le; bub = ifa.id_ex_bubble; ft = ifa.fetch_timeout; st = ifa.state;
      end else begin
        pcd = ifb.PC_D; npcd = ifb.nPC_D; s_pc = ifb.stallPC; s_npc = ifb.stallnPC;
        le = ifb.if_id_le; bub = ifb.id_ex_bubble; ft = ifb.fetch_timeout; st = ifb.state;
      end
      chk({e.tag, ".PC_D"}, pcd, e.pcd);
      chk({e.tag, ".nPC_D"}, npcd, e.npcd);
      chk({e.tag, ".stallPC"}, 32'(s_pc), 32'(e.go));
      chk({e.tag, ".stallnPC"}, 32'(s_npc), 32'(e.go));
      chk({e.tag, ".if_id_le"}, 32'(le), 32'(e.go));
      chk({e.tag, ".bubble"}, 32'(bub), 32'(!e.go));
      chk({e.tag, ".timeout"}, 32'(ft), 32'(e.ft));
      chk({e.tag, ".state"}, 32'(st), 32'(e.st));
      $display("cycle %0d dut%0d %s: PC_D=%08h nPC_D=%08h go=%0b ft=%0b st=%0d",
               cycle, e.d, e.tag, pcd, npcd, s_pc, ft, st);
    end
  end

  task automatic idle(input int d);
    if (d == 0) begin
      ifa.PC_Q = 32'd0; ifa.nPC_Q = 32'd4; ifa.branch_taken = 1'b0; ifa.branch_target = 32'd0;
      ifa.imem_ready = 1'b1; ifa.id_ex_mem_read = 1'b0; ifa.id_ex_rt = 5'd0;
      ifa.if_id_rs = 5'd0; ifa.if_id_rt = 5'd0; ifa.if_id_uses_rt = 1'b0;
    end else begin
      ifb.PC_Q = 32'd0; ifb.nPC_Q = 32'd4; ifb.branch_taken = 1'b0; ifb.branch_target = 32'd0;
      ifb.imem_ready = 1'b1; ifb.id_ex_mem_read = 1'b0; ifb.id_ex_rt = 5'd0;
      ifb.if_id_rs = 5'd0; ifb.if_id_rt = 5'd0; ifb.if_id_uses_rt = 1'b0;
    end
  endtask

  // Drive one DUT; the other sits idle (ready, no hazard, no branch).
  task automatic apply(input int d, input logic rdy, input logic br, input logic [31:0] tgt,
                       input logic [31:0] pcq, input logic [31:0] npcq, input logic ld,
                       input logic [4:0] exrt, input logic [4:0] rs, input logic [4:0] idrt,
                       input logic uses);
    idle(1 - d);
    if (d == 0) begin
      ifa.PC_Q = pcq; ifa.nPC_Q = npcq; ifa.branch_taken = br; ifa.branch_target = tgt;
      ifa.imem_ready = rdy; ifa.id_ex_mem_read = ld; ifa.id_ex_rt = exrt;
      ifa.if_id_rs = rs; ifa.if_id_rt = idrt; ifa.if_id_uses_rt = uses;
    end else begin
      ifb.PC_Q = pcq; ifb.nPC_Q = npcq; ifb.branch_taken = br; ifb.branch_target = tgt;
      ifb.imem_ready = rdy; ifb.id_ex_mem_read = ld; ifb.id_ex_rt = exrt;
      ifb.if_id_rs = rs; ifb.if_id_rt = idrt; ifb.if_id_uses_rt = uses;
    end
  endtask

  task automatic push_exp(input int d, input string tag, input logic [31:0] pcd,
                          input logic [31:0] npcd, input logic go, input logic ft,
                          input logic [1:0] st);
    exp_t e;
    e.d = d; e.cyc = cycle; e.tag = tag; e.pcd = pcd; e.npcd = npcd;
    e.go = go; e.ft = ft; e.st = st;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    idle(0);
    idle(1);
    tick();

    // Reset cycle: enables forced off on both instances.
    Reset = 1'b1;
    apply(0, 1, 0, 0, 32'd0, 32'd4, 0, 0, 0, 0, 0);
    push_exp(0, "rst_a", 32'd4, 32'd8, 0, 0, 0);
    push_exp(1, "rst_b", 32'd4, 32'd8, 0, 0, 0);
    tick();
    Reset = 1'b0;

    // Sequential fetch: (0,4)->(4,8)->(8,12)
    apply(0, 1, 0, 0, 32'd0, 32'd4, 0, 0, 0, 0, 0);
    push_exp(0, "seq0", 32'd4, 32'd8, 1, 0, 0);
    tick();
    apply(0, 1, 0, 0, 32'd4, 32'd8, 0, 0, 0, 0, 0);
    push_exp(0, "seq1", 32'd8, 32'd12, 1, 0, 0);
    tick();
    apply(0, 1, 0, 0, 32'd8, 32'd12, 0, 0, 0, 0, 0);
    push_exp(0, "seq2", 32'd12, 32'd16, 1, 0, 0);
    tick();

    // Taken branch with delay slot.
    apply(0, 1, 1, 32'h100, 32'd8, 32'd12, 0, 0, 0, 0, 0);
    push_exp(0, "branch", 32'd12, 32'h100, 1, 0, 0);
    tick();
    apply(0, 1, 0, 0, 32'd12, 32'h100, 0, 0, 0, 0, 0);
    push_exp(0, "post_br", 32'h100, 32'h104, 1, 0, 0);
    tick();

    // Load-use, single-cycle interlock (rs match).
    apply(0, 1, 0, 0, 32'h100, 32'h104, 1, 5'd5, 5'd5, 0, 0);
    push_exp(0, "hz1", 32'h104, 32'h108, 0, 0, 0);
    tick();
    apply(0, 1, 0, 0, 32'h100, 32'h104, 0, 0, 0, 0, 0);
    push_exp(0, "hz1_done", 32'h104, 32'h108, 1, 0, 0);
    tick();
    // rt match only counts when ID reads rt.
    apply(0, 1, 0, 0, 32'h104, 32'h108, 1, 5'd7, 5'd0, 5'd7, 1);
    push_exp(0, "hz_rt", 32'h108, 32'h10C, 0, 0, 0);
    tick();
    apply(0, 1, 0, 0, 32'h104, 32'h108, 1, 5'd7, 5'd0, 5'd7, 0);
    push_exp(0, "hz_rt_unused", 32'h108, 32'h10C, 1, 0, 0);
    tick();
    // Load into r0 never stalls.
    apply(0, 1, 0, 0, 32'h108, 32'h10C, 1, 5'd0, 5'd0, 5'd0, 1);
    push_exp(0, "hz_r0", 32'h10C, 32'h110, 1, 0, 0);
    tick();

    // Three-cycle interlock; branch requested during the stall is not loaded.
    apply(1, 1, 0, 0, 32'h200, 32'h204, 1, 5'd5, 5'd5, 0, 0);
    push_exp(1, "hz3_run", 32'h204, 32'h208, 0, 0, 0);
    tick();
    apply(1, 1, 1, 32'h400, 32'h200, 32'h204, 0, 0, 0, 0, 0);
    push_exp(1, "hz3_h1", 32'h204, 32'h400, 0, 0, 1);
    tick();
    apply(1, 1, 1, 32'h400, 32'h200, 32'h204, 0, 0, 0, 0, 0);
    push_exp(1, "hz3_h2", 32'h204, 32'h400, 0, 0, 1);
    tick();
    apply(1, 1, 1, 32'h400, 32'h200, 32'h204, 0, 0, 0, 0, 0);
    push_exp(1, "hz3_resume", 32'h204, 32'h400, 1, 0, 0);
    tick();

    // Memory wait: 4 cycles not ready, then ready.
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 0, 32'h300, 32'h304, 0, 0, 0, 0, 0);
      push_exp(0, $sformatf("fw%0d", i), 32'h304, 32'h308, 0, 0, (i == 0) ? 2'd0 : 2'd2);
      tick();
    end
    apply(0, 1, 0, 0, 32'h300, 32'h304, 0, 0, 0, 0, 0);
    push_exp(0, "fw_ready", 32'h304, 32'h308, 0, 0, 2);
    tick();
    apply(0, 1, 0, 0, 32'h300, 32'h304, 0, 0, 0, 0, 0);
    push_exp(0, "fw_resume", 32'h304, 32'h308, 1, 0, 0);
    tick();

    // Timeout with MAX_WAIT=4: 10 cycles not ready.
    for (int i = 0; i < 10; i++) begin
      apply(1, 0, 0, 0, 32'h500, 32'h504, 0, 0, 0, 0, 0);
      push_exp(1, $sformatf("to%0d", i), 32'h504, 32'h508, 0, (i >= 5) ? 1'b1 : 1'b0,
               (i == 0) ? 2'd0 : 2'd2);
      tick();
    end
    apply(1, 1, 0, 0, 32'h500, 32'h504, 0, 0, 0, 0, 0);
    push_exp(1, "to_ready", 32'h504, 32'h508, 0, 1, 2);
    tick();
    apply(1, 1, 0, 0, 32'h500, 32'h504, 0, 0, 0, 0, 0);
    push_exp(1, "to_sticky", 32'h504, 32'h508, 1, 1, 0);
    tick();

    // Reset in the middle of a HAZARD stall; wraparound of nPC+4.
    apply(1, 1, 0, 0, 32'hFFFFFFF8, 32'hFFFFFFFC, 1, 5'd5, 5'd5, 0, 0);
    push_exp(1, "rh_run", 32'hFFFFFFFC, 32'h0, 0, 1, 0);
    tick();
    Reset = 1'b1;
    apply(1, 1, 0, 0, 32'hFFFFFFF8, 32'hFFFFFFFC, 0, 0, 0, 0, 0);
    push_exp(1, "rh_reset", 32'hFFFFFFFC, 32'h0, 0, 1, 1);
    tick();
    Reset = 1'b0;
    apply(1, 1, 0, 0, 32'hFFFFFFF8, 32'hFFFFFFFC, 0, 0, 0, 0, 0);
    push_exp(1, "rh_after", 32'hFFFFFFFC, 32'h0, 1, 0, 0);
    tick();
    apply(1, 1, 0, 0, 32'hFFFFFFFC, 32'h0, 0, 0, 0, 0, 0);
    push_exp(1, "rh_next", 32'h0, 32'h4, 1, 0, 0);
    tick();

    @(negedge Clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
